ysyx_wb_arb: RTL and testbench

Round-robin arbiter that shares the single register-file write port (reg_write_en/waddr/wdata) between N_REQ writeback requesters (ALU commit, LSU load return, CSR/mul-div return).
- Per-port valid/ready handshake; one grant per cycle.
- Granted request is registered once and driven to the register file the following cycle.
- Sits between the execution/commit units and the register file; also reports per-port grant counts for performance monitoring.

---
 rtl/ysyx_wb_arb_if.sv | 30 +++
 rtl/ysyx_wb_arb.sv | 106 ++++++++++
 tb/tb_ysyx_wb_arb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_wb_arb_if.sv
// Writeback arbiter bus: requester handshake, register-file write port,
// grant counters and busy flag. The arbiter connects through the slave
// modport; the requester/register-file side uses the master modport.
interface ysyx_wb_arb_if #(
    parameter int N_REQ      = 3,
    parameter int REG_ADDR_W = 4,
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*REG_ADDR_W-1:0] req_addr;
    logic [N_REQ*XLEN-1:0]       req_data;
    logic                        stall;
    logic                        reg_write_en;
    logic [REG_ADDR_W-1:0]       waddr;
    logic [XLEN-1:0]             wdata;
    logic [N_REQ*CNT_W-1:0]      grant_cnt;
    logic                        busy;

    modport slave (
        input  req_valid, req_addr, req_data, stall,
        output req_ready, reg_write_en, waddr, wdata, grant_cnt, busy
    );

    modport master (
        output req_valid, req_addr, req_data, stall,
        input  req_ready, reg_write_en, waddr, wdata, grant_cnt, busy
    );
endinterface

// File: rtl/ysyx_wb_arb.sv
// Writeback arbiter: shares the single register-file write port between
// N_REQ requesters. One grant per cycle, registered once and presented to
// the register file on the following cycle. Per-port grant counters wrap.
// Build option YSYX_WB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; the rotating pointer is then not built.
module ysyx_wb_arb #(
    parameter int N_REQ      = 3,
    parameter int REG_ADDR_W = 4,
    parameter int XLEN       = 32,
    parameter int CNT_W      = 16
) (
    input  logic            clock,
    input  logic            reset,
    ysyx_wb_arb_if.slave    bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]      win;
    logic                  win_vld;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [XLEN-1:0]       sel_data;
    logic [CNT_W-1:0]      cnt_q [N_REQ];
    logic                  we_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;

`ifdef YSYX_WB_FIXED_PRIO_EN
    // Fixed priority: scan from the top so the lowest valid index is left as the winner
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                win     = PTR_W'(k);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand;

    // Round-robin search starting one past the last winner, wrapping to it last
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_vld && bus.req_valid[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    // Pointer follows the last granted port; idle and stalled cycles leave it alone
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_ptr <= PTR_W'(N_REQ - 1);
        else if (xfer)
            rr_ptr <= win;
    end
`endif

    // Reset gates ready combinationally so nothing is accepted while held in reset
    assign xfer          = win_vld & ~bus.stall & reset;
    assign bus.req_ready = xfer ? ({{(N_REQ-1){1'b0}}, 1'b1} << win) : '0;
    assign sel_addr      = bus.req_addr[int'(win)*REG_ADDR_W +: REG_ADDR_W];
    assign sel_data      = bus.req_data[int'(win)*XLEN +: XLEN];

    // Output stage: x0 writes are accepted but never strobe the register file
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (xfer) begin
            we_q    <= (sel_addr != '0);
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
        end else begin
            we_q    <= 1'b0;
        end
    end

    // Per-port grant counters, free-running modulo 2^CNT_W
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++)
                cnt_q[i] <= '0;
        end else if (xfer) begin
            cnt_q[win] <= cnt_q[win] + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign bus.grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    assign bus.reg_write_en = we_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.busy         = (|bus.req_valid) | we_q;
endmodule

// File: tb/tb_ysyx_wb_arb.sv
// Bench for ysyx_wb_arb: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_ysyx_wb_arb;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    ysyx_wb_arb_if #(.N_REQ(N), .REG_ADDR_W(AW), .XLEN(DW), .CNT_W(CW)) bus ();

    ysyx_wb_arb #(.N_REQ(N), .REG_ADDR_W(AW), .XLEN(DW), .CNT_W(CW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model state
    int          m_ptr = N - 1;
    logic        m_we = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_wdata = '0;
    int          m_cnt [N] = '{default: 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which port should be granted now, or -1 if none
    function automatic int exp_win(input logic [N-1:0] v, input int ptr);
        int idx;
`ifdef YSYX_WB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            idx = (ptr + k) % N;
            if (v[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic logic [CW-1:0] dut_cnt(input int i);
        logic [N*CW-1:0] all;
        all = bus.grant_cnt;
        return all[i*CW +: CW];
    endfunction

    // Model update on the same edges the hardware reacts to
    always @(posedge clock or negedge reset) begin
        int w;
        logic [N*AW-1:0] a;
        logic [N*DW-1:0] d;
        if (!reset) begin
            m_we    <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_ptr   <= N - 1;
            for (int i = 0; i < N; i++) m_cnt[i] <= 0;
        end else begin
            w = bus.stall ? -1 : exp_win(bus.req_valid, m_ptr);
            a = bus.req_addr;
            d = bus.req_data;
            if (w >= 0) begin
                m_we    <= (a[w*AW +: AW] != 0);
                m_waddr <= a[w*AW +: AW];
                m_wdata <= d[w*DW +: DW];
                m_ptr   <= w;
                m_cnt[w] <= (m_cnt[w] + 1) % (1 << CW);
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    // Compare process: every output against the model, away from the active edge
    always @(negedge clock) begin
        int w;
        logic [N-1:0] er;
        w  = exp_win(bus.req_valid, m_ptr);
        er = (reset && !bus.stall && w >= 0) ? (N'(1) << w) : '0;
        chk("ready", 64'(bus.req_ready), 64'(er));
        chk("we", 64'(bus.reg_write_en), 64'(m_we));
        chk("waddr", 64'(bus.waddr), 64'(m_waddr));
        chk("wdata", 64'(bus.wdata), 64'(m_wdata));
        chk("busy", 64'(bus.busy), 64'((|bus.req_valid) | m_we));
        for (int i = 0; i < N; i++)
            chk("grant_cnt", 64'(dut_cnt(i)), 64'(m_cnt[i]));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.stall     = 1'b0;
        repeat (2) cyc();

        // 1: all ports valid, distinct addresses -> 0,1,2,0 rotation
        reset = 1'b1;
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd3, 4'd2, 4'd1};
        bus.req_data  = {32'h33, 32'h22, 32'h11};
        #1;
        chk("t1_ready0", 64'(bus.req_ready), 64'h1);
        chk("t1_we0", 64'(bus.reg_write_en), 64'h0);
        cyc();
        chk("t1_ready1", 64'(bus.req_ready), 64'h2);
        chk("t1_waddr1", 64'(bus.waddr), 64'h1);
        chk("t1_wdata1", 64'(bus.wdata), 64'h11);
        cyc();
        chk("t1_ready2", 64'(bus.req_ready), 64'h4);
        chk("t1_waddr2", 64'(bus.waddr), 64'h2);
        cyc();
        chk("t1_ready3", 64'(bus.req_ready), 64'h1);
        chk("t1_waddr3", 64'(bus.waddr), 64'h3);
        chk("t1_cnt", 64'(bus.grant_cnt), {16'h0, 16'h1, 16'h1, 16'h1});
        bus.req_valid = '0;
        cyc();
        chk("t1_idle_we", 64'(bus.reg_write_en), 64'h0);

        // 2: x0 write on port1 is accepted but never strobes
        bus.req_valid = 3'b010;
        bus.req_addr  = {4'd3, 4'd0, 4'd1};
        bus.req_data  = {32'h33, 32'hDEAD, 32'h11};
        #1;
        chk("t2_ready", 64'(bus.req_ready), 64'h2);
        cyc();
        chk("t2_we", 64'(bus.reg_write_en), 64'h0);
        chk("t2_cnt1", 64'(dut_cnt(1)), 64'h2);

        // 3: pointer at port0, ports 0 and 2 both write x5 -> port2 then port0
        bus.req_valid = 3'b001;
        bus.req_addr  = {4'd3, 4'd0, 4'd7};
        cyc();
        bus.req_valid = 3'b101;
        bus.req_addr  = {4'd5, 4'd0, 4'd5};
        bus.req_data  = {32'hB, 32'h0, 32'hA};
        #1;
        chk("t3_ready_first", 64'(bus.req_ready), 64'h4);
        cyc();
        chk("t3_wdata_first", 64'(bus.wdata), 64'hB);
        chk("t3_ready_second", 64'(bus.req_ready), 64'h1);
        cyc();
        chk("t3_waddr_final", 64'(bus.waddr), 64'h5);
        chk("t3_wdata_final", 64'(bus.wdata), 64'hA);
        chk("t3_we_final", 64'(bus.reg_write_en), 64'h1);

        // 4: stall freezes grants but lets the latched write complete
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd3, 4'd2, 4'd1};
        bus.req_data  = {32'h33, 32'h22, 32'h11};
        cyc();
        bus.stall = 1'b1;
        #1;
        chk("t4_ready_stall", 64'(bus.req_ready), 64'h0);
        chk("t4_pending_we", 64'(bus.reg_write_en), 64'h1);
        chk("t4_pending_addr", 64'(bus.waddr), 64'h2);
        repeat (4) begin
            cyc();
            chk("t4_we_stalled", 64'(bus.reg_write_en), 64'h0);
        end
        bus.stall = 1'b0;
        #1;
        chk("t4_resume_ready", 64'(bus.req_ready), 64'h4);
        cyc();
        chk("t4_resume_addr", 64'(bus.waddr), 64'h3);

        // 5: reset right after a handshake discards the pending write at once
        #2;
        reset = 1'b0;
        #1;
        chk("t5_we", 64'(bus.reg_write_en), 64'h0);
        chk("t5_cnt", 64'(bus.grant_cnt), 64'h0);
        chk("t5_ready", 64'(bus.req_ready), 64'h0);
        chk("t5_waddr", 64'(bus.waddr), 64'h0);
        repeat (2) cyc();
        reset = 1'b1;

        // Random traffic, with occasional stalls and resets
        for (int n = 0; n < 1500; n++) begin
            bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                bus.req_addr[i*AW +: AW] = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom);
                bus.req_data[i*DW +: DW] = $urandom;
            end
            bus.stall = ($urandom_range(0, 9) == 0);
            reset     = ($urandom_range(0, 199) != 0);
            cyc();
        end
        reset = 1'b1;
        bus.stall = 1'b0;
        cyc();

        // 6: grant counter wraps after 65536 grants on one port
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        bus.req_valid = 3'b001;
        bus.req_addr  = {4'd3, 4'd2, 4'd1};
        repeat (65535) cyc();
        chk("t6_cnt_max", 64'(dut_cnt(0)), 64'hFFFF);
        cyc();
        chk("t6_cnt_wrap", 64'(dut_cnt(0)), 64'h0);
        bus.req_valid = '0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
